// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle.
//   B    : raw asynchronous button pin (driven by the board / master)
//   L    : debounced level, 1 = pressed (driven by the debouncer)
//   BUSY : 1 while a candidate level change is being qualified
interface button_debouncer_if;
    logic B;
    logic L;
    logic BUSY;

    // Board side: drives the pin, observes the cleaned level
    modport master (
        output B,
        input  L,
        input  BUSY
    );

    // Debouncer side
    modport slave (
        input  B,
        output L,
        output BUSY
    );
endinterface : button_debouncer_if

// File: rtl/button_debouncer.sv
// Push-button debouncer.
//   Synchronises the raw pin through two flops, optionally inverts it so that
//   1 always means "pressed", and only moves the debounced level L after the
//   synchronised value has held a new state for STABLE_CYCLES cycles.
// Ports:
//   CLK    : clock, all logic on the rising edge
//   RST    : synchronous reset, active-high, priority over everything
//   io_btn : button_debouncer_if.slave (B in, L / BUSY out, both registered)
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    button_debouncer_if.slave  io_btn
);

    localparam longint unsigned LP_CNT_MAX  = (64'(1) << CNT_W) - 64'(1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic             LP_INV      = (ACTIVE_LOW != 0);

    // Reject configurations where the counter could not reach its terminal value
    if ((STABLE_CYCLES < 2) || (64'(STABLE_CYCLES) > LP_CNT_MAX)) begin : g_bad_cfg
        $error("button_debouncer: STABLE_CYCLES out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_l;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_done;

    // Two-flop synchroniser; reset value is "not pressed" after inversion
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= io_btn.B ^ LP_INV;
            r_s2 <= r_s1;
        end
    end

    assign w_cnt_done = (r_cnt == LP_CNT_LAST);

    // Next-state and counter logic; any reversion in a WAIT state restarts from LOW/HIGH
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOW: begin
                if (r_s2) begin
                    w_state_nxt = ST_RISE_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_RISE_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = ST_FALL_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_FALL_WAIT: begin
                if (r_s2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register; L and BUSY are registered decodes of the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_l     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_l     <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_WAIT);
            r_busy  <= (w_state_nxt == ST_RISE_WAIT) || (w_state_nxt == ST_FALL_WAIT);
        end
    end

    assign io_btn.L    = r_l;
    assign io_btn.BUSY = r_busy;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer: an active-low instance (u_dut0) and an
// active-high instance (u_dut1), both STABLE_CYCLES=4. Each cycle the
// stimulus pushes the hand-computed L/BUSY expected after the next edge; a
// monitor pops and compares just after every rising edge.
module tb_button_debouncer;

    logic CLK;
    logic RST;

    button_debouncer_if bif0 ();
    button_debouncer_if bif1 ();

    button_debouncer #(
        .STABLE_CYCLES (4),
        .CNT_W         (20),
        .ACTIVE_LOW    (1)
    ) u_dut0 (
        .CLK    (CLK),
        .RST    (RST),
        .io_btn (bif0)
    );

    button_debouncer #(
        .STABLE_CYCLES (4),
        .CNT_W         (20),
        .ACTIVE_LOW    (0)
    ) u_dut1 (
        .CLK    (CLK),
        .RST    (RST),
        .io_btn (bif1)
    );

    typedef struct {
        logic  l0;
        logic  bz0;
        logic  l1;
        logic  bz1;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stim_done = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic cyc(input logic rst, input logic b0, input logic b1,
                       input logic l0, input logic bz0, input logic l1, input logic bz1,
                       input string tag, input int n = 1);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            RST     = rst;
            bif0.B  = b0;
            bif1.B  = b1;
            e.l0    = l0;
            e.bz0   = bz0;
            e.l1    = l1;
            e.bz1   = bz1;
            e.tag   = tag;
            exp_q.push_back(e);
            @(negedge CLK);
        end
    endtask

    task automatic chk(input string name, input string tag, input logic act, input logic exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s %s: got %b expected %b at %0t", tag, name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare every cycle for which an expectation exists
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dut0.L",    e.tag, bif0.L,    e.l0);
            chk("dut0.BUSY", e.tag, bif0.BUSY, e.bz0);
            chk("dut1.L",    e.tag, bif1.L,    e.l1);
            chk("dut1.BUSY", e.tag, bif1.BUSY, e.bz1);
        end
    end

    // dut0 pin: 0 = pressed, 1 = released. dut1 pin: 1 = pressed.
    initial begin
        // 1. reset for 3 cycles with dut0 pressed, then release
        cyc(1, 0, 0, 0, 0, 0, 0, "rst_hold", 3);
        cyc(0, 0, 0, 0, 0, 0, 0, "rst_sync", 2);
        cyc(0, 0, 0, 0, 1, 0, 0, "rst_qual", 3);
        cyc(0, 0, 0, 1, 0, 0, 0, "rst_press", 3);

        // 2. clean release then clean press
        cyc(0, 1, 0, 1, 0, 0, 0, "rel_sync", 2);
        cyc(0, 1, 0, 1, 1, 0, 0, "rel_qual", 3);
        cyc(0, 1, 0, 0, 0, 0, 0, "rel_done", 3);
        cyc(0, 0, 0, 0, 0, 0, 0, "prs_sync", 2);
        cyc(0, 0, 0, 0, 1, 0, 0, "prs_qual", 3);
        cyc(0, 0, 0, 1, 0, 0, 0, "prs_done", 3);
        cyc(0, 1, 0, 1, 0, 0, 0, "rel2_sync", 2);
        cyc(0, 1, 0, 1, 1, 0, 0, "rel2_qual", 3);
        cyc(0, 1, 0, 0, 0, 0, 0, "rel2_done", 3);

        // 3. bounce 0,1,0,1 then hold pressed
        cyc(0, 0, 0, 0, 0, 0, 0, "bnc_e1");
        cyc(0, 1, 0, 0, 0, 0, 0, "bnc_e2");
        cyc(0, 0, 0, 0, 1, 0, 0, "bnc_e3");
        cyc(0, 1, 0, 0, 0, 0, 0, "bnc_e4");
        cyc(0, 0, 0, 0, 1, 0, 0, "bnc_e5");
        cyc(0, 0, 0, 0, 0, 0, 0, "bnc_e6");
        cyc(0, 0, 0, 0, 1, 0, 0, "bnc_qual", 3);
        cyc(0, 0, 0, 1, 0, 0, 0, "bnc_press", 2);
        cyc(0, 1, 0, 1, 0, 0, 0, "bnc_rel_sync", 2);
        cyc(0, 1, 0, 1, 1, 0, 0, "bnc_rel_qual", 3);
        cyc(0, 1, 0, 0, 0, 0, 0, "bnc_rel_done", 3);

        // 4. three-cycle glitch never reaches L
        cyc(0, 0, 0, 0, 0, 0, 0, "gl_sync", 2);
        cyc(0, 0, 0, 0, 1, 0, 0, "gl_qual");
        cyc(0, 1, 0, 0, 1, 0, 0, "gl_qual2", 2);
        cyc(0, 1, 0, 0, 0, 0, 0, "gl_drop", 4);

        // 5. reset while RISE_WAIT count=2, then released pin stays quiet
        cyc(0, 0, 0, 0, 0, 0, 0, "mr_sync", 2);
        cyc(0, 0, 0, 0, 1, 0, 0, "mr_qual", 2);
        cyc(1, 0, 0, 0, 0, 0, 0, "mr_rst");
        cyc(0, 1, 0, 0, 0, 0, 0, "mr_quiet", 10);

        // 6. active-high instance: press then release
        cyc(0, 1, 1, 0, 0, 0, 0, "ah_sync", 2);
        cyc(0, 1, 1, 0, 0, 0, 1, "ah_qual", 3);
        cyc(0, 1, 1, 0, 0, 1, 0, "ah_press", 3);
        cyc(0, 1, 0, 0, 0, 1, 0, "ah_rel_sync", 2);
        cyc(0, 1, 0, 0, 0, 1, 1, "ah_rel_qual", 3);
        cyc(0, 1, 0, 0, 0, 0, 0, "ah_rel_done", 3);

        @(posedge CLK);
        #2;
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout: stimulus not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_button_debouncer
